// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO stream-drain block:
//   DATA_WIDTH_DEF  default width of FIFO read data / stream data
//   RD_LATENCY_DEF  default FIFO read latency (ren sample -> rdata valid)
//   BEAT_CNT_W      width of the accepted-beat counter
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int RD_LATENCY_DEF = 2;
  localparam int BEAT_CNT_W     = 16;

  // Advance a circular-buffer pointer, wrapping from depth-1 back to 0.
  function automatic int wrap_inc(input int ptr, input int depth);
    if (ptr >= depth - 32'sd1) begin
      return 32'sd0;
    end else begin
      return ptr + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/fifo_stream_drain_if.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain_if
// Bundles the FIFO read side and the outgoing valid/ready stream.
//   ff_empty  FIFO empty flag            (environment -> drain)
//   ff_ren    FIFO read enable           (drain -> environment)
//   ff_rdata  FIFO read data             (environment -> drain)
//   m_valid   stream word available      (drain -> environment)
//   m_ready   downstream accepts word    (environment -> drain)
//   m_data    stream word                (drain -> environment)
// master: the drain block; slave: the FIFO + downstream consumer.
// -----------------------------------------------------------------------------
interface fifo_stream_drain_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  ff_empty;
  logic                  ff_ren;
  logic [DATA_WIDTH-1:0] ff_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  ff_empty,
    input  ff_rdata,
    input  m_ready,
    output ff_ren,
    output m_valid,
    output m_data
  );

  modport slave (
    output ff_empty,
    output ff_rdata,
    output m_ready,
    input  ff_ren,
    input  m_valid,
    input  m_data
  );

endinterface

// File: rtl/drain_skid_buf.sv
// -----------------------------------------------------------------------------
// drain_skid_buf
// Circular skid buffer that catches words returning from the FIFO read
// pipeline. Push writes at tail, pop advances head; head/tail wrap at DEPTH-1.
//   clk, rst   clock, synchronous active-high reset
//   push       write push_data at tail this cycle
//   push_data  word to store
//   pop        consume the head entry this cycle (ignored when empty)
//   head_data  head entry, zero while the buffer is empty
//   count      number of stored entries
// -----------------------------------------------------------------------------
module drain_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = RD_LATENCY_DEF + 2,
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [CW-1:0]         count_r;
  logic                  do_push_s;
  logic                  do_pop_s;
  logic                  full_s;
  logic                  empty_s;

  // Qualify push/pop: popping an empty buffer is a no-op, and a push into a
  // full buffer is only taken when the same cycle frees a slot.
  always_comb begin
    empty_s   = (count_r == {CW{1'b0}});
    full_s    = (count_r == CW'(DEPTH));
    do_pop_s  = pop && !empty_s;
    do_push_s = push && (!full_s || do_pop_s);
  end

  // Storage array; no reset needed since entries are only read once counted.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        tail_r <= PW'(wrap_inc(32'(tail_r), DEPTH));
      end else begin
        tail_r <= tail_r;
      end
      if (do_pop_s) begin
        head_r <= PW'(wrap_inc(32'(head_r), DEPTH));
      end else begin
        head_r <= head_r;
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Present the head entry; force zero while empty so reset shows m_data=0.
  always_comb begin
    if (!empty_s) begin
      head_data = mem_r[head_r];
    end else begin
      head_data = {DATA_WIDTH{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// fifo_stream_drain
// Drains a fixed-latency FIFO into a valid/ready stream. Reads are issued only
// while the words already in flight plus the words already buffered leave room
// in the local skid buffer, so the buffer can never overflow even when the
// downstream stalls indefinitely.
//   clk       clock (posedge)
//   rst       synchronous active-high reset
//   en        1 = issue FIFO reads, 0 = stop issuing (in-flight still land)
//   bus       fifo_stream_drain_if.master (ff_empty/ff_ren/ff_rdata,
//             m_valid/m_ready/m_data)
//   busy      reads in flight or words buffered
//   beat_cnt  number of accepted stream beats, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LATENCY = RD_LATENCY_DEF,
  parameter int BUF_DEPTH  = RD_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  fifo_stream_drain_if.master   bus,
  output logic                  busy,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [RD_LATENCY-1:0] pipe_r;
  logic [CW-1:0]         inflight_s;
  logic [CW-1:0]         buf_cnt_s;
  logic [CW:0]           credit_used_s;
  logic                  ren_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  m_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [BEAT_CNT_W-1:0] beat_cnt_r;

  // Count outstanding reads: one per set bit in the in-flight pipeline.
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + CW'(pipe_r[i]);
    end
  end

  // Credit check: a read is issued only if its word is guaranteed a slot.
  always_comb begin
    credit_used_s = {1'b0, inflight_s} + {1'b0, buf_cnt_s};
    ren_s         = en && !bus.ff_empty && (credit_used_s < (CW + 1)'(BUF_DEPTH));
  end

  // In-flight valid pipeline: bit 0 is the newest read, the top bit marks
  // the cycle in which that read's data is present on ff_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_r <= {RD_LATENCY{1'b0}};
    end else begin
      pipe_r[0] <= ren_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Stream handshake derived from buffer occupancy; no bypass path.
  always_comb begin
    push_s    = pipe_r[RD_LATENCY-1];
    m_valid_s = (buf_cnt_s != {CW{1'b0}});
    pop_s     = m_valid_s && bus.m_ready;
  end

  drain_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (bus.ff_rdata),
    .pop        (pop_s),
    .head_data  (head_data_s),
    .count      (buf_cnt_s)
  );

  // Accepted-beat counter; the natural 16-bit overflow gives the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_r <= {BEAT_CNT_W{1'b0}};
    end else if (pop_s) begin
      beat_cnt_r <= beat_cnt_r + {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  assign bus.ff_ren  = ren_s;
  assign bus.m_valid = m_valid_s;
  assign bus.m_data  = head_data_s;
  assign busy        = (inflight_s != {CW{1'b0}}) || (buf_cnt_s != {CW{1'b0}});
  assign beat_cnt    = beat_cnt_r;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_drain
// Directed bench: a behavioural 2-cycle-latency FIFO feeds the drain block,
// a consumer logs every accepted beat, and each scenario compares against
// hand-computed values through check_eq.
// -----------------------------------------------------------------------------
module tb_fifo_stream_drain;

  logic        clk;
  logic        rst;
  logic        en;
  logic        busy;
  logic [15:0] beat_cnt;

  fifo_stream_drain_if #(.DATA_WIDTH(32)) bus ();

  fifo_stream_drain #(
    .DATA_WIDTH (32),
    .RD_LATENCY (2),
    .BUF_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  // FIFO model state
  logic [31:0] fifo_mem [256];
  int          fifo_wr;
  int          fifo_rd;
  logic [31:0] rd_pipe0;
  logic [31:0] rd_pipe1;

  // Bookkeeping
  int          n_checks;
  int          n_pass;
  int          n_fail;
  int          cyc_no;
  int          ren_cnt;
  int          ren_empty_err;
  int          first_ren;
  int          first_val;
  int          first_pop;
  int          last_pop;
  logic [31:0] got_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: data appears on ff_rdata two clocks after ren is sampled.
  always @(posedge clk) begin
    if (rst) begin
      fifo_rd  <= 0;
      rd_pipe0 <= 32'h0;
      rd_pipe1 <= 32'h0;
    end else begin
      if (bus.ff_ren) begin
        rd_pipe0 <= fifo_mem[fifo_rd[7:0]];
        fifo_rd  <= fifo_rd + 1;
      end
      rd_pipe1 <= rd_pipe0;
    end
  end

  assign bus.ff_empty = (fifo_rd == fifo_wr);
  assign bus.ff_rdata = rd_pipe1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observe the settled cycle, log events, then advance to the next negedge.
  task automatic cyc();
    #1;
    if (bus.ff_ren) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc_no;
      if (bus.ff_empty) ren_empty_err++;
    end
    if (bus.m_valid && first_val < 0) first_val = cyc_no;
    if (bus.m_valid && bus.m_ready) begin
      got_q.push_back(bus.m_data);
      if (first_pop < 0) first_pop = cyc_no;
      last_pop = cyc_no;
    end
    @(negedge clk);
    cyc_no++;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_mem[fifo_wr[7:0]] = base + 32'(i);
      fifo_wr++;
    end
  endtask

  task automatic clear_log();
    got_q.delete();
    cyc_no    = 0;
    ren_cnt   = 0;
    first_ren = -1;
    first_val = -1;
    first_pop = -1;
    last_pop  = -1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    en          = 1'b0;
    bus.m_ready = 1'b0;
    fifo_wr     = 0;
    cyc();
    cyc();
    clear_log();
    rst = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) cyc();
  endtask

  task automatic check_words(input string tag, input int n, input logic [31:0] base);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq({tag, "_data"}, got_q[i], base + 32'(i));
    end
  endtask

  initial begin
    logic [31:0] hold_val;
    logic        have_hold;
    int          guard;

    n_checks      = 0;
    n_pass        = 0;
    n_fail        = 0;
    ren_empty_err = 0;
    fifo_wr       = 0;
    rst           = 1'b1;
    en            = 1'b0;
    bus.m_ready   = 1'b0;
    clear_log();
    @(negedge clk);

    // Reset state
    do_reset();
    check_eq("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("rst_m_data", bus.m_data, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check_eq("rst_ff_ren", 32'(bus.ff_ren), 32'd0);

    // Streaming 0x1..0x8 with m_ready held high
    load(8, 32'h1);
    en          = 1'b1;
    bus.m_ready = 1'b1;
    run_until(8, 40);
    cyc();
    cyc();
    check_words("stream", 8, 32'h1);
    check_eq("stream_first_ren_cycle", 32'(first_ren), 32'd0);
    check_eq("stream_latency", 32'(first_val - first_ren), 32'd3);
    check_eq("stream_back_to_back", 32'(last_pop - first_pop), 32'd7);
    check_eq("stream_ren_cnt", 32'(ren_cnt), 32'd8);
    check_eq("stream_beat_cnt", 32'(beat_cnt), 32'd8);
    check_eq("stream_busy_end", 32'(busy), 32'd0);

    // Back-pressure: 10 words, m_ready low -> only BUF_DEPTH reads
    do_reset();
    load(10, 32'h10);
    en = 1'b1;
    for (int i = 0; i < 12; i++) cyc();
    check_eq("bp_ren_cnt", 32'(ren_cnt), 32'd4);
    check_eq("bp_ren_stopped", 32'(bus.ff_ren), 32'd0);
    check_eq("bp_m_valid", 32'(bus.m_valid), 32'd1);
    check_eq("bp_head_stable", bus.m_data, 32'h10);
    check_eq("bp_busy", 32'(busy), 32'd1);
    bus.m_ready = 1'b1;
    run_until(10, 60);
    check_words("bp", 10, 32'h10);
    check_eq("bp_beat_cnt", 32'(beat_cnt), 32'd10);

    // m_ready toggling: data must hold through every stall
    do_reset();
    load(6, 32'h20);
    en        = 1'b1;
    have_hold = 1'b0;
    hold_val  = 32'h0;
    for (int i = 0; i < 40 && got_q.size() < 6; i++) begin
      bus.m_ready = (i % 2 == 0);
      if (have_hold) begin
        check_eq("stall_hold", bus.m_data, hold_val);
        have_hold = 1'b0;
      end
      if (bus.m_valid && !bus.m_ready) begin
        hold_val  = bus.m_data;
        have_hold = 1'b1;
      end
      cyc();
    end
    bus.m_ready = 1'b0;
    cyc();
    check_words("toggle", 6, 32'h20);
    check_eq("toggle_beat_cnt", 32'(beat_cnt), 32'd6);

    // en dropped after two reads: both delivered, no more reads
    do_reset();
    load(6, 32'h30);
    en          = 1'b1;
    bus.m_ready = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    #1;
    check_eq("endrop_ren_off", 32'(bus.ff_ren), 32'd0);
    check_eq("endrop_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) cyc();
    check_words("endrop", 2, 32'h30);
    check_eq("endrop_ren_cnt", 32'(ren_cnt), 32'd2);
    check_eq("endrop_busy_end", 32'(busy), 32'd0);
    check_eq("endrop_beat_cnt", 32'(beat_cnt), 32'd2);

    // Reset with 2 in flight and 2 buffered
    do_reset();
    load(8, 32'h40);
    en = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check_eq("midrst_pre_valid", 32'(bus.m_valid), 32'd1);
    check_eq("midrst_pre_ren_cnt", 32'(ren_cnt), 32'd4);
    rst     = 1'b1;
    fifo_wr = 0;
    cyc();
    got_q.delete();
    check_eq("midrst_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    check_eq("midrst_m_data", bus.m_data, 32'h0);
    rst = 1'b0;
    load(3, 32'h50);
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    check_words("midrst_fresh", 3, 32'h50);

    // beat_cnt wrap: 65535 beats, then one more
    do_reset();
    fifo_wr     = 65536;
    en          = 1'b1;
    bus.m_ready = 1'b1;
    guard       = 0;
    while (beat_cnt != 16'hFFFF && guard < 70000) begin
      cyc();
      guard++;
    end
    bus.m_ready = 1'b0;
    en          = 1'b0;
    check_eq("wrap_pre", 32'(beat_cnt), 32'hFFFF);
    check_eq("wrap_valid", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    cyc();
    bus.m_ready = 1'b0;
    cyc();
    check_eq("wrap_zero", 32'(beat_cnt), 32'd0);

    check_eq("ren_while_empty", 32'(ren_empty_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
FIFO_STREAM_DRAIN -- requirements
Module: fifo_stream_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 Parameter RD_LATENCY, default 2, clocks from FIFO ren sample to valid ff_rdata.
REQ-003 Parameter BUF_DEPTH, default RD_LATENCY+2, local skid-buffer entries; SHALL be >= RD_LATENCY+1.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  1 = drain FIFO; 0 = stop issuing new reads.
REQ-007 ff_empty  in  1  FIFO empty flag.
REQ-008 ff_ren  out  1  FIFO read enable.
REQ-009 ff_rdata  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY clocks after ff_ren sampled high.
REQ-010 m_valid  out  1  stream word available.
REQ-011 m_ready  in  1  downstream accepts word.
REQ-012 m_data  out  DATA_WIDTH  stream word.
REQ-013 busy  out  1  reads in flight or words buffered.
REQ-014 beat_cnt  out  16  count of accepted stream beats, wraps 0xFFFF->0.

Function
REQ-015 ff_ren SHALL be combinational: en && !ff_empty && (inflight + buf_cnt) < BUF_DEPTH.
REQ-016 Each cycle with ff_ren=1 SHALL shift a 1 into an RD_LATENCY-deep in-flight valid pipeline; else shift 0.
REQ-017 When the pipeline output is 1, ff_rdata SHALL be written into the buffer tail that cycle.
REQ-018 Buffer SHALL be a circular array, BUF_DEPTH entries, head/tail pointers wrapping at BUF_DEPTH-1 -> 0.
REQ-019 m_valid SHALL equal (buf_cnt != 0); m_data SHALL be the head entry, stable while m_valid && !m_ready.
REQ-020 Pop SHALL occur when m_valid && m_ready; head advances by 1, beat_cnt increments by 1.
REQ-021 Simultaneous push and pop SHALL leave buf_cnt unchanged; pushing into an empty buffer makes m_valid high the next cycle (no bypass).
REQ-022 inflight SHALL equal the number of 1s in the pipeline; credit check (REQ-015) SHALL guarantee buffer never overflows, even with m_ready held 0.
REQ-023 en falling SHALL stop new reads immediately; in-flight words SHALL still be captured and delivered.
REQ-024 busy SHALL equal (inflight != 0) || (buf_cnt != 0).
REQ-025 Throughput: with FIFO non-empty and m_ready=1, one word per clock sustained after initial RD_LATENCY+1 clocks.
REQ-026 Data order at m_data SHALL equal FIFO read order; no word duplicated or dropped.
REQ-027 ff_ren high while ff_empty=1 SHALL never occur.

Reset
REQ-028 On rst=1 at posedge: ff_ren=0, m_valid=0, m_data=0, busy=0, beat_cnt=0, pipeline cleared, head=tail=buf_cnt=0.
REQ-029 Reset mid-operation SHALL discard in-flight and buffered words; upstream FIFO shares rst and is reset the same cycle.
REQ-030 First ff_ren SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-031 Shared package fifo_pkg SHALL hold DATA_WIDTH default, RD_LATENCY default and the beat_cnt width constant.
REQ-032 Buffer SHALL be one sub-module, drain_skid_buf (circular array, push/pop, count); credit and pipeline logic in the top.

Verification
REQ-033 FIFO preloaded 0x1..0x8, en=1, m_ready=1 -> m_data 0x1..0x8 on consecutive cycles starting 3 clocks after first ff_ren; beat_cnt=8, busy=0 at end.
REQ-034 FIFO holds 10 words, m_ready=0 -> exactly BUF_DEPTH (4) ff_ren pulses, then ff_ren stays 0; raise m_ready -> all 10 delivered in order.
REQ-035 m_ready toggling 1,0,1,0 with 6 words -> m_data held stable through each stall, no loss, beat_cnt=6.
REQ-036 en dropped 1 cycle after 2 reads issued -> both words delivered, no further ff_ren, busy falls after last pop.
REQ-037 rst asserted with 2 in flight and 2 buffered -> next cycle m_valid=0, busy=0, beat_cnt=0; no stale word appears afterwards.
REQ-038 beat_cnt preset via 65535 beats then 1 more -> beat_cnt=0.
